// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the 32-bit to 16-bit memory access unit:
// FSM encoding, halfword stride and halfword address helper.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [31:0] HALF_STRIDE = 32'd2;

    // Byte address of halfword index h inside the 512-byte data memory
    function automatic logic [31:0] half_addr(input logic [7:0] h);
        return {24'h000000, h} * HALF_STRIDE;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline request/response and 16-bit data memory signals of the access unit.
// master = pipeline plus memory side, slave = the access unit itself.
interface mem_access_unit_if;
    import mem_access_unit_pkg::*;

    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addres;
    logic [31:0] mem_wdata;
    logic        mem_w;
    logic        mem_r;
    logic [31:0] mem_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, mem_rdata,
        input  busy, resp_valid, resp_rdata, resp_err,
        input  mem_addres, mem_wdata, mem_w, mem_r
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mem_rdata,
        output busy, resp_valid, resp_rdata, resp_err,
        output mem_addres, mem_wdata, mem_w, mem_r
    );

endinterface

// File: rtl/mem_access_unit.sv
// Splits each 32-bit load/store into two little-endian 16-bit memory accesses
// (low half at H, high half at H+1 mod 256) and returns a one-cycle response.
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    mem_access_unit_if.slave bus
);

    state_t      state_r;
    logic        write_r;
    logic        misalign_r;
    logic [7:0]  hidx_r;
    logic [15:0] wdata_hi_r;
    logic [15:0] lo_buf_r;
    logic        busy_r;
    logic        resp_valid_r;
    logic [31:0] resp_rdata_r;
    logic        resp_err_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wdata_r;
    logic        mem_w_r;
    logic        mem_r_r;
    logic        unused_s;

    // Only the halfword index of the address and the low memory lane matter
    assign unused_s = ^{bus.req_addr[31:9], bus.mem_rdata[31:16]};

    // Request sequencer: state, latched request, load buffer and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            write_r      <= 1'b0;
            misalign_r   <= 1'b0;
            hidx_r       <= 8'h00;
            wdata_hi_r   <= 16'h0000;
            lo_buf_r     <= 16'h0000;
            busy_r       <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            resp_err_r   <= 1'b0;
            mem_addr_r   <= 32'h0000_0000;
            mem_wdata_r  <= 32'h0000_0000;
            mem_w_r      <= 1'b0;
            mem_r_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req_valid) begin
                        state_r     <= LO;
                        write_r     <= bus.req_write;
                        misalign_r  <= bus.req_addr[0];
                        hidx_r      <= bus.req_addr[8:1];
                        wdata_hi_r  <= bus.req_wdata[31:16];
                        busy_r      <= 1'b1;
                        mem_addr_r  <= half_addr(bus.req_addr[8:1]);
                        mem_w_r     <= bus.req_write;
                        mem_r_r     <= ~bus.req_write;
                        mem_wdata_r <= bus.req_write ? {16'h0000, bus.req_wdata[15:0]} : 32'h0000_0000;
                    end else begin
                        state_r     <= IDLE;
                        busy_r      <= 1'b0;
                        mem_addr_r  <= 32'h0000_0000;
                        mem_wdata_r <= 32'h0000_0000;
                        mem_w_r     <= 1'b0;
                        mem_r_r     <= 1'b0;
                    end
                    resp_valid_r <= 1'b0;
                    resp_rdata_r <= 32'h0000_0000;
                    resp_err_r   <= 1'b0;
                end
                LO: begin
                    state_r     <= HI;
                    lo_buf_r    <= write_r ? 16'h0000 : bus.mem_rdata[15:0];
                    mem_addr_r  <= half_addr(hidx_r + 8'd1);
                    mem_wdata_r <= write_r ? {16'h0000, wdata_hi_r} : 32'h0000_0000;
                end
                HI: begin
                    // The high half is taken straight off the bus into the response register
                    state_r      <= DONE;
                    mem_addr_r   <= 32'h0000_0000;
                    mem_wdata_r  <= 32'h0000_0000;
                    mem_w_r      <= 1'b0;
                    mem_r_r      <= 1'b0;
                    resp_valid_r <= 1'b1;
                    resp_rdata_r <= write_r ? 32'h0000_0000 : {bus.mem_rdata[15:0], lo_buf_r};
                    resp_err_r   <= misalign_r;
                end
                DONE: begin
                    state_r      <= IDLE;
                    busy_r       <= 1'b0;
                    resp_valid_r <= 1'b0;
                    resp_rdata_r <= 32'h0000_0000;
                    resp_err_r   <= 1'b0;
                end
                default: begin
                    state_r      <= IDLE;
                    busy_r       <= 1'b0;
                    resp_valid_r <= 1'b0;
                    resp_rdata_r <= 32'h0000_0000;
                    resp_err_r   <= 1'b0;
                    mem_addr_r   <= 32'h0000_0000;
                    mem_wdata_r  <= 32'h0000_0000;
                    mem_w_r      <= 1'b0;
                    mem_r_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.mem_addres = mem_addr_r;
    assign bus.mem_wdata  = mem_wdata_r;
    // Strobes are masked by rst so a reset edge can never complete a write
    assign bus.mem_w      = mem_w_r & ~rst;
    assign bus.mem_r      = mem_r_r & ~rst;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port req_valid, input, 1 bit: pipeline presents a 32-bit load/store request.
REQ-004 SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-005 SHALL have port req_addr, input, 32 bits: byte address of the 32-bit word.
REQ-006 SHALL have port req_wdata, input, 32 bits: store data.
REQ-007 SHALL have port busy, output, 1 bit: unit is occupied; pipeline stalls while 1.
REQ-008 SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have port resp_rdata, output, 32 bits: assembled load data, valid with resp_valid.
REQ-010 SHALL have port resp_err, output, 1 bit: misaligned request flag, valid with resp_valid.
REQ-011 SHALL have port mem_addres, output, 32 bits: byte address to the 16-bit data memory.
REQ-012 SHALL have port mem_wdata, output, 32 bits: memory write data, {16'h0000, half}.
REQ-013 SHALL have port mem_w, output, 1 bit: memory write enable; memory writes on the clk edge.
REQ-014 SHALL have port mem_r, output, 1 bit: memory read enable; memory read is combinational.
REQ-015 SHALL have port mem_rdata, input, 32 bits: memory read data; only bits [15:0] are used.

Function
REQ-016 SHALL split each 32-bit access into two 16-bit accesses, little-endian: low half at halfword index H = req_addr[8:1], high half at (H+1) mod 256.
REQ-017 SHALL implement FSM states IDLE, LO, HI, DONE: IDLE->LO on req_valid; LO->HI; HI->DONE; DONE->IDLE, all unconditional except IDLE.
REQ-018 SHALL latch req_write, req_addr and req_wdata on the edge leaving IDLE; inputs are ignored in all other states.
REQ-019 SHALL drive busy = 1 in LO, HI and DONE, and 0 in IDLE; a request is accepted only when busy = 0.
REQ-020 SHALL, in LO, drive mem_addres = {23'b0, H, 1'b0}; in HI, drive {23'b0, H+1 (8-bit wrap), 1'b0}; in IDLE and DONE, drive 0.
REQ-021 SHALL, for stores, assert mem_w in LO with mem_wdata[15:0] = wdata[15:0], and in HI with wdata[31:16]; mem_r = 0.
REQ-022 SHALL, for loads, assert mem_r in LO and HI with mem_w = 0, and capture mem_rdata[15:0] into low/high buffer at the end of LO/HI.
REQ-023 SHALL pulse resp_valid for exactly the DONE cycle: acceptance edge at cycle 0, memory phases in cycles 1-2, resp_valid in cycle 3; throughput is one request per 4 cycles.
REQ-024 SHALL present resp_rdata = {high, low} for loads and 0 for stores, and hold 0 outside DONE.
REQ-025 SHALL, if req_addr[0] = 1, ignore bit 0 (treat the request as aligned to H), complete normally, and assert resp_err in DONE; otherwise resp_err = 0.
REQ-026 SHALL allow a new request to be accepted in the cycle after DONE (IDLE), with no dead cycle beyond that.
REQ-027 SHALL gate mem_w and mem_r with !rst so that no memory write occurs on any edge where rst = 1.

Reset
REQ-028 SHALL, on rst = 1 at a clk edge, enter IDLE and clear buffers and latched request; this includes reset taken mid-operation, where the partial store is left as written (LO half only) and no resp_valid is produced.
REQ-029 SHALL hold all outputs at 0 after reset (busy, resp_valid, resp_rdata, resp_err, mem_addres, mem_wdata, mem_w, mem_r).

Structure
REQ-030 SHALL take the state encoding (2-bit IDLE=0, LO=1, HI=2, DONE=3) and HALF_STRIDE = 2 from the shared project package.
REQ-031 SHALL be a single module with no sub-modules; the bench instantiates it together with data_memory.

Verification
REQ-032 Store 0xDEADBEEF at 0x10, then load 0x10 -> halfword 8 = 0xBEEF, halfword 9 = 0xDEAD; load resp_rdata = 0xDEADBEEF, resp_valid in cycle 3.
REQ-033 Store 0x12345678 at 0x1FE -> halfword 255 = 0x5678, halfword 0 = 0x1234 (wrap); load 0x1FE returns 0x12345678.
REQ-034 req_valid held high for 6 cycles with a changing address -> only the first address is accepted; busy = 1 for cycles 1-3; the second request is accepted at cycle 4.
REQ-035 Load at 0x21 -> treated as 0x20; resp_err = 1 with resp_valid; data equals the load from 0x20.
REQ-036 Store 0xAAAA5555 at 0x40, rst pulsed in HI -> halfword 32 = 0x5555, halfword 33 unchanged, no resp_valid, all outputs 0 the following cycle.
REQ-037 After reset with no requests -> busy = mem_w = mem_r = resp_valid = 0 for 10 cycles.
